// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS CPU: datapath defaults, branch
// type encodings and ALU operation codes.
package cpu_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10,
        BR_LTU  = 2'b11
    } br_type_e;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

endpackage

// File: rtl/ex_mem_reg_branch_cond.sv
// Combinational branch resolution from the ALU comparison flags; shared with
// any early-branch unit.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [1:0] br_type,
    input  logic       a_eq_b,
    input  logic       a_less_b,
    input  logic       valid,
    output logic       taken
);

    // Select the flag that decides each branch flavour.
    always_comb begin
        taken = 1'b0;
        case (br_type_e'(br_type))
            BR_NONE: taken = 1'b0;
            BR_EQ:   taken = valid & a_eq_b;
            BR_NE:   taken = valid & ~a_eq_b;
            BR_LTU:  taken = valid & a_less_b;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU results and control, resolves
// branches into a one-cycle redirect pulse, and counts retired/taken events.
module ex_mem_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic                  ex_a_eq_b,
    input  logic                  ex_a_less_b,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_mem_to_reg,
    input  logic [1:0]            ex_br_type,
    input  logic [DATA_W-1:0]     ex_br_target,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_result,
    output logic [DATA_W-1:0]     mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_to_reg,
    output logic                  redirect,
    output logic [DATA_W-1:0]     redirect_pc,
    output logic                  load_pending,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [CNT_W-1:0]      taken_cnt
);

    logic                  taken_s;
    logic                  load_s;
    logic                  valid_r;
    logic [DATA_W-1:0]     result_r;
    logic [DATA_W-1:0]     store_data_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic                  reg_write_r;
    logic                  mem_read_r;
    logic                  mem_write_r;
    logic                  mem_to_reg_r;
    logic                  redirect_r;
    logic [DATA_W-1:0]     redirect_pc_r;
    logic                  load_pending_r;
    logic [CNT_W-1:0]      retired_r;
    logic [CNT_W-1:0]      taken_r;

    branch_cond u_branch_cond (
        .br_type  (ex_br_type),
        .a_eq_b   (ex_a_eq_b),
        .a_less_b (ex_a_less_b),
        .valid    (ex_valid),
        .taken    (taken_s)
    );

    assign load_s = ~flush & ~stall;

    // Pipeline entry: flush squashes control, stall holds, otherwise capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r        <= 1'b0;
            result_r       <= '0;
            store_data_r   <= '0;
            rd_r           <= '0;
            reg_write_r    <= 1'b0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_to_reg_r   <= 1'b0;
            redirect_r     <= 1'b0;
            redirect_pc_r  <= '0;
            load_pending_r <= 1'b0;
        end else if (flush) begin
            // Data fields keep stale values; nothing downstream reads them without valid.
            valid_r        <= 1'b0;
            reg_write_r    <= 1'b0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_to_reg_r   <= 1'b0;
            redirect_r     <= 1'b0;
            load_pending_r <= 1'b0;
        end else if (stall) begin
            redirect_r     <= 1'b0;
        end else begin
            valid_r        <= ex_valid;
            result_r       <= ex_result;
            store_data_r   <= ex_store_data;
            rd_r           <= ex_rd;
            reg_write_r    <= ex_valid & ex_reg_write & (ex_rd != '0);
            mem_read_r     <= ex_valid & ex_mem_read;
            mem_write_r    <= ex_valid & ex_mem_write;
            mem_to_reg_r   <= ex_valid & ex_mem_to_reg;
            redirect_r     <= taken_s;
            redirect_pc_r  <= ex_br_target;
            load_pending_r <= ex_valid & ex_mem_read;
        end
    end

    // Statistics: an entry retires when it leaves to WB; taken counts loaded redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= '0;
            taken_r   <= '0;
        end else begin
            if (valid_r && !stall) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
            if (load_s && taken_s) begin
                taken_r <= taken_r + CNT_W'(1);
            end else begin
                taken_r <= taken_r;
            end
        end
    end

    assign mem_valid      = valid_r;
    assign mem_result     = result_r;
    assign mem_store_data = store_data_r;
    assign mem_rd         = rd_r;
    assign mem_reg_write  = reg_write_r;
    assign mem_mem_read   = mem_read_r;
    assign mem_mem_write  = mem_write_r;
    assign mem_mem_to_reg = mem_to_reg_r;
    assign redirect       = redirect_r;
    assign redirect_pc    = redirect_pc_r;
    assign load_pending   = load_pending_r;
    assign retired_cnt    = retired_r;
    assign taken_cnt      = taken_r;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized bench for ex_mem_reg against a cycle-level behavioural model,
// plus a 4-bit-counter instance for the wrap case.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, ex_valid = 1'b0;
    logic [31:0] ex_result = '0, ex_store_data = '0, ex_br_target = '0;
    logic        ex_a_eq_b = 1'b0, ex_a_less_b = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0, ex_mem_to_reg = 1'b0;
    logic [1:0]  ex_br_type = 2'b00;

    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic        redirect, load_pending;
    logic [31:0] mem_result, mem_store_data, redirect_pc, retired_cnt, taken_cnt;
    logic [4:0]  mem_rd;

    logic        s_valid, s_rw, s_mr, s_mw, s_m2r, s_redirect, s_lp;
    logic [31:0] s_result, s_store, s_pc;
    logic [4:0]  s_rd;
    logic [3:0]  s_retired, s_taken;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_result(ex_result), .ex_a_eq_b(ex_a_eq_b), .ex_a_less_b(ex_a_less_b),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_br_type(ex_br_type), .ex_br_target(ex_br_target),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .redirect(redirect), .redirect_pc(redirect_pc), .load_pending(load_pending),
        .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
    );

    ex_mem_reg #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_result(ex_result), .ex_a_eq_b(ex_a_eq_b), .ex_a_less_b(ex_a_less_b),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_br_type(ex_br_type), .ex_br_target(ex_br_target),
        .mem_valid(s_valid), .mem_result(s_result), .mem_store_data(s_store),
        .mem_rd(s_rd), .mem_reg_write(s_rw), .mem_mem_read(s_mr),
        .mem_mem_write(s_mw), .mem_mem_to_reg(s_m2r),
        .redirect(s_redirect), .redirect_pc(s_pc), .load_pending(s_lp),
        .retired_cnt(s_retired), .taken_cnt(s_taken)
    );

    // Behavioural model of what the MEM stage must present.
    logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_redirect;
    logic [31:0] m_result, m_store, m_pc, m_retired, m_taken;
    logic [4:0]  m_rd;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0;
        m_redirect = 1'b0; m_result = '0; m_store = '0; m_pc = '0; m_rd = '0;
        m_retired = '0; m_taken = '0;
    endtask

    task automatic compare_all();
        chk("mem_valid", {31'd0, mem_valid}, {31'd0, m_valid});
        chk("mem_reg_write", {31'd0, mem_reg_write}, {31'd0, m_rw});
        chk("mem_mem_read", {31'd0, mem_mem_read}, {31'd0, m_mr});
        chk("mem_mem_write", {31'd0, mem_mem_write}, {31'd0, m_mw});
        chk("mem_mem_to_reg", {31'd0, mem_mem_to_reg}, {31'd0, m_m2r});
        chk("redirect", {31'd0, redirect}, {31'd0, m_redirect});
        chk("load_pending", {31'd0, load_pending}, {31'd0, m_valid & m_mr});
        chk("retired_cnt", retired_cnt, m_retired);
        chk("taken_cnt", taken_cnt, m_taken);
        chk("small_retired", {28'd0, s_retired}, {28'd0, m_retired[3:0]});
        chk("small_taken", {28'd0, s_taken}, {28'd0, m_taken[3:0]});
        if (m_valid) begin
            chk("mem_result", mem_result, m_result);
            chk("mem_store_data", mem_store_data, m_store);
            chk("mem_rd", {27'd0, mem_rd}, {27'd0, m_rd});
        end
        if (m_redirect) chk("redirect_pc", redirect_pc, m_pc);
    endtask

    // One clock edge: advance the model from the inputs present at the edge.
    task automatic tick();
        logic [3:0] cond;
        logic       tk;
        cond = {ex_a_less_b, ~ex_a_eq_b, ex_a_eq_b, 1'b0};
        tk = ex_valid & cond[ex_br_type];
        @(posedge clk);
        if (m_valid && !stall) m_retired = m_retired + 32'd1;
        if (flush) begin
            m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0;
            m_redirect = 1'b0;
        end else if (stall) begin
            m_redirect = 1'b0;
        end else begin
            m_valid = ex_valid;
            m_result = ex_result;
            m_store = ex_store_data;
            m_rd = ex_rd;
            m_rw = ex_valid & ex_reg_write & (ex_rd != 5'd0);
            m_mr = ex_valid & ex_mem_read;
            m_mw = ex_valid & ex_mem_write;
            m_m2r = ex_valid & ex_mem_to_reg;
            m_redirect = tk;
            m_pc = ex_br_target;
            if (tk) m_taken = m_taken + 32'd1;
        end
        #1;
        compare_all();
    endtask

    task automatic idle();
        ex_valid = 1'b0; stall = 1'b0; flush = 1'b0; ex_br_type = 2'b00;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_to_reg = 1'b0;
    endtask

    task automatic instr(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                         input logic [1:0] bt, input logic eq, input logic less,
                         input logic [31:0] tgt);
        idle();
        ex_valid = 1'b1; ex_result = res; ex_rd = rd; ex_reg_write = rw;
        ex_br_type = bt; ex_a_eq_b = eq; ex_a_less_b = less; ex_br_target = tgt;
        ex_store_data = $urandom;
    endtask

    task automatic randomize_inputs(input int stall_pct, input int flush_pct);
        ex_valid = ($urandom_range(0, 99) < 80);
        ex_result = $urandom; ex_store_data = $urandom; ex_br_target = $urandom;
        ex_a_eq_b = 1'($urandom); ex_a_less_b = 1'($urandom);
        ex_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
        ex_mem_write = 1'($urandom); ex_mem_to_reg = 1'($urandom);
        ex_br_type = 2'($urandom);
        stall = ($urandom_range(0, 99) < stall_pct);
        flush = ($urandom_range(0, 99) < flush_pct);
    endtask

    // Async reset between edges: outputs must clear without waiting for a clock.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_result", mem_result, 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_retired", retired_cnt, 32'd0);
        chk("rst_taken", taken_cnt, 32'd0);
        compare_all();
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        model_clear();
        idle();
        #12;
        compare_all();
        chk("init_result", mem_result, 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU pass-through and retirement one edge later
        instr(32'h0000_0007, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        chk("pass_result", mem_result, 32'h0000_0007);
        chk("pass_rd", {27'd0, mem_rd}, 32'd3);
        chk("pass_rw", {31'd0, mem_reg_write}, 32'd1);
        idle();
        tick();
        chk("pass_retired", retired_cnt, 32'd1);

        // $0 guard
        instr(32'h1234_5678, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        chk("zero_rw", {31'd0, mem_reg_write}, 32'd0);
        chk("zero_valid", {31'd0, mem_valid}, 32'd1);

        // beq taken, then pulse drops
        instr(32'h0, 5'd0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0000_0040);
        tick();
        chk("beq_redirect", {31'd0, redirect}, 32'd1);
        chk("beq_pc", redirect_pc, 32'h0000_0040);
        chk("beq_taken", taken_cnt, 32'd1);
        idle();
        tick();
        chk("beq_pulse_end", {31'd0, redirect}, 32'd0);

        // bne with eq=1: not taken
        instr(32'h0, 5'd0, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0000_0080);
        tick();
        chk("bne_redirect", {31'd0, redirect}, 32'd0);

        // bltu with less=1: taken
        instr(32'h0, 5'd0, 1'b0, 2'b11, 1'b0, 1'b1, 32'h0000_00c0);
        tick();
        chk("bltu_redirect", {31'd0, redirect}, 32'd1);
        chk("bltu_taken", taken_cnt, 32'd2);

        // Taken branch captured then held by 3 stall cycles
        instr(32'h0000_00aa, 5'd9, 1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0100);
        tick();
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(0, 0);
            stall = 1'b1;
            tick();
            chk("stall_redirect", {31'd0, redirect}, 32'd0);
            chk("stall_result", mem_result, 32'h0000_00aa);
        end
        idle();
        tick();

        // flush and stall together over a taken sw
        instr(32'h0, 5'd0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0000_0200);
        ex_mem_write = 1'b1;
        flush = 1'b1; stall = 1'b1;
        tick();
        chk("fs_valid", {31'd0, mem_valid}, 32'd0);
        chk("fs_mw", {31'd0, mem_mem_write}, 32'd0);
        chk("fs_redirect", {31'd0, redirect}, 32'd0);
        chk("fs_taken", taken_cnt, 32'd3);
        idle();
        tick();

        // Randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) mid_reset();
            else begin
                randomize_inputs(25, 10);
                tick();
            end
        end

        // Reset mid-stream, then 17 retirements wrap the 4-bit counter to 1
        mid_reset();
        chk("post_rst_valid", {31'd0, mem_valid}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            instr($urandom, 5'd4, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
            tick();
        end
        idle();
        tick();
        chk("wrap_small", {28'd0, s_retired}, 32'd1);
        chk("wrap_full", retired_cnt, 32'd17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the 8-instruction pipelined MIPS CPU, directly downstream of the ALU.
- Captures the ALU Result, AequalsB and AlessB flags, store data and control from the EX stage.
- Resolves conditional branches from the captured flags and issues a one-cycle PC redirect.
- Supports stall and flush from the hazard unit, and keeps retired-instruction and taken-branch counters.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data, PC).
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, width of the retired and taken-branch counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all state (MEM stage busy).
- flush  in  1  squash the instruction being captured.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_result  in  DATA_W  ALU Result.
- ex_a_eq_b  in  1  ALU AequalsB.
- ex_a_less_b  in  1  ALU AlessB (unsigned compare).
- ex_store_data  in  DATA_W  rt value for sw.
- ex_rd  in  REG_ADDR_W  destination register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  in  1 each  decoded control.
- ex_br_type  in  2  00 none, 01 beq, 10 bne, 11 bltu.
- ex_br_target  in  DATA_W  computed branch target.
- mem_valid  out  1  registered valid.
- mem_result, mem_store_data  out  DATA_W  registered data.
- mem_rd  out  REG_ADDR_W  registered destination.
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1 each  registered control.
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  DATA_W  registered branch target.
- load_pending  out  1  mem_valid & mem_mem_read, used by the hazard unit.
- retired_cnt, taken_cnt  out  CNT_W  statistics counters.

Behaviour:
- Reset (rst_n=0, asynchronous): every output and internal register is 0, including redirect and both counters. Release is synchronous to the next clk edge.
- Latency: one cycle from the EX inputs to the mem_* outputs.
- Per-edge priority: flush > stall > load. flush and stall asserted together means flush wins.
- Load:
  - All mem_* data registers take their ex_* values. mem_valid is set to ex_valid.
  - The control bits are gated by ex_valid, so an invalid instruction never writes or accesses memory.
  - mem_reg_write is forced to 0 when ex_rd==0, because $0 is never written.
- Branch condition:
  - taken = ex_valid & ((type 01 & eq) | (type 10 & !eq) | (type 11 & less)).
  - On load, redirect is registered as taken and redirect_pc as ex_br_target.
  - redirect is high for exactly one cycle: it is cleared on the following edge regardless of stall, and it is not reasserted while stall holds the entry.
- Stall: all mem_* registers and redirect_pc hold their values. redirect goes to 0. The counters do not change.
- Flush: mem_valid, all four control outputs and redirect go to 0. Data registers may keep stale values. A branch being captured under flush never redirects and is not counted.
- Counters:
  - retired_cnt increments on each edge where mem_valid=1 and stall=0, meaning the entry leaves to WB.
  - taken_cnt increments on each edge where redirect is loaded as 1.
  - Both counters wrap modulo 2^CNT_W with no saturation.
- Branch shadow: this block does not squash younger instructions itself. The hazard unit flushes IF/ID and ID/EX when redirect=1.
- Reset during a stall or a pending redirect: the asynchronous clear wins immediately and no redirect pulse escapes.

Decomposition:
- Shared package (cpu_pkg) holds:
  - the BR_NONE/BR_EQ/BR_NE/BR_LTU encodings;
  - the DATA_W and REG_ADDR_W defaults;
  - the ALU_Ctr constants (0 add, 1 sub, 2 and, 3 or), shared with the ALU.
- One natural sub-module: branch_cond, a pure combinational function (type, eq, less, valid) → taken, reused later by any early-branch unit.

Test Plan:
- Reset mid-stream: run traffic, pull rst_n low between edges → all outputs 0 immediately. After release with ex_valid=0, the outputs stay 0.
- ALU pass-through: ex_result=0x0000_0007, rd=3, reg_write=1 → next edge mem_result=7, mem_rd=3, mem_reg_write=1, retired_cnt +1 one edge later.
- $0 guard: ex_rd=0, reg_write=1, valid=1 → mem_reg_write=0 and mem_valid=1.
- Branch:
  - beq with eq=1, target 0x40 → redirect=1 for one cycle, redirect_pc=0x40, taken_cnt=1.
  - bne with eq=1 → no redirect.
  - bltu with less=1 → redirect.
- Stall hold: capture a taken branch, then stall for 3 cycles → redirect high only in the first cycle, mem_* unchanged, retired_cnt frozen. After release, retired_cnt +1.
- flush+stall together while ex carries a taken sw → mem_valid=0, mem_mem_write=0, redirect=0, taken_cnt unchanged.
- Counter wrap: preload the count via CNT_W=4 and retire 17 instructions → retired_cnt=1.
